mips_pipe_cpu: RTL and testbench
================================

// Module: mips_pipe_cpu
// PURPOSE
//  Five-stage (IF/ID/EX/MEM/WB) in-order 32-bit MIPS-subset core with internal instruction memory,
//  data memory and register file. Has forwarding, a load-use/branch hazard unit, and branches/jumps
//  resolved in ID with no delay slot. Top-level core; the bench preloads memories and observes debug ports.
// PARAMETERS
//  IM_WORDS  256   instruction memory depth in words, indexed by pc[9:2]
//  DM_WORDS  1024  data memory depth in words, indexed by addr[11:2], so 0x2000 maps to word 0
// PORTS
//  clock      in   1   rising-edge clock
//  reset_n    in   1   synchronous, active-low reset
//  cycle      out  32  cycles since reset
//  pc         out  32  current IF program counter (byte address)
//  if_inst    out  32  instruction fetched this cycle
//  wb_we      out  1   register write strobe in WB
//  wb_reg     out  5   WB destination register
//  wb_data    out  32  WB write data
//  alu_ovf    out  1   signed overflow of the current EX add/sub/addi
// BEHAVIOUR
//  - Reset (clock edge with reset_n=0): pc=0, cycle=0, all pipeline registers become NOP
//    (control all zero), wb_we=0, alu_ovf=0. Register file and memories are not reset.
//  - ISA:
//    - R-type: add 20, addu 21, sub 22, subu 23, and 24, or 25, xor 26, nor 27, jr 08.
//    - I-type: addi 08 (sign-extended imm), andi 0C and ori 0D (zero-extended imm), lw 23, sw 2B,
//      beq 04, bne 05, bgtz 07 (rs>0 signed).
//    - J-type: j 02.
//    - Any other opcode executes as a NOP. Writes to $0 are discarded; $0 always reads 0.
//  - Register file is write-first: a WB write is visible to an ID read in the same cycle.
//  - EX forwarding: EX/MEM has priority over MEM/WB; never forward $0. Example: lw $9 followed by
//    add $9 followed by a use of $9 sees the add result.
//  - Load-use stall: EX holds lw and ID reads its rt/rs. Hold pc and IF/ID, insert one bubble into EX.
//  - Branches and jr compare/read in ID with forwarding from EX/MEM and MEM/WB.
//    - Producer ALU op in EX: stall 1 cycle.
//    - Producer lw in EX: stall 2 cycles. Producer lw in MEM: stall 1 cycle.
//  - Targets:
//    - branch = pc4 + (sext(imm)<<2)
//    - j = {pc4[31:28], idx, 2'b00}
//    - jr = rs
//  - Taken branch/jump: flush IF/ID, which costs 1 bubble. Not-taken branches cost nothing.
//  - lw: data is read in MEM and written back in WB.
//  - sw: data memory is written at the rising edge ending MEM, using the forwarded rt value.
//  - Arithmetic wraps modulo 2^32. alu_ovf=1 for signed overflow of add, sub or addi in EX.
//  - Stall and flush in the same cycle: the flush wins, and pc takes the target.
// CONFIGURATION
//  - OVF_SUPPRESS_EN defined: an add/sub/addi with alu_ovf=1 has its register write suppressed
//    (becomes a NOP from MEM on).
//  - OVF_SUPPRESS_EN undefined: the wrapped result is written; alu_ovf is still reported.
// TESTING
//  - Arrays are preloaded hierarchically through instance names: IM.instructmem[], DM.datamem[],
//    piperegs.regfile[]. All registers and DM words 0..9 start at 0.
//  - Reset: hold reset_n=0 for 2 clocks, then release.
//    -> pc=0, cycle=0, wb_we=0; pc advances by 4 per cycle thereafter.
//  - ALU/forwarding program:
//    - Setup: addi $8=0x2000; xor-clear $9..$12; addi $9=1, $10=2, $11=-1; lw $12,0($8).
//    - Then each op writes $13, is stored at 0($8), and $8 += 4.
//    - Required DM[1..9] = 0, 3, 2, 1, 1, 0x10, 3, 0, 0xFFFFFFFE (add, add, sub, subu, and, andi 0x10,
//      or, nor, xor).
//  - Loop with bgtz, no delay slot:
//    - Code: addi $13,$13,1; bgtz $13,+1; j back.
//    - Start $13=0xFFFFFFFE -> exits when $13=1; DM[10]=1.
//  - bne not taken:
//    - Code: bne $13,$9,+1 with both =1, then xor $13=0; store.
//    - -> DM[11]=0 (fall-through executed).
//  - jr with forwarded rs:
//    - Code: addi $14=200; xor $13; jr $14 skips addi 16.
//    - Target addi $13+=8 -> DM[12]=8.
//  - Load-use and WAW:
//    - Code: addi $14=0x2000; lw $9,0($14); add $9=$10+$11; add $11=$9+$9; sw $11.
//    - -> DM[13]=2.

Source files
------------

// File: rtl/mips_pipe_cpu.sv
// mips_pipe_cpu: five-stage MIPS-subset core (IF/ID/EX/MEM/WB) with internal memories, forwarding
// and ID-resolved branches. Define OVF_SUPPRESS_EN to drop the write of an overflowing add/sub/addi.
module mips_pipe_cpu #(
    parameter int IM_WORDS = 256,
    parameter int DM_WORDS = 1024
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [31:0] cycle,
    output logic [31:0] pc,
    output logic [31:0] if_inst,
    output logic        wb_we,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        alu_ovf
);
    localparam int IAW = $clog2(IM_WORDS);
    localparam int DAW = $clog2(DM_WORDS);

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR} alu_op_e;
    typedef struct packed { logic [31:0] inst; logic [31:0] pc4; } ifid_t;
    typedef struct packed {
        logic we; logic [4:0] dst; logic mem_rd; logic mem_wr; alu_op_e op; logic use_imm;
        logic ovf_chk; logic [4:0] rs; logic [4:0] rt; logic [31:0] a; logic [31:0] b; logic [31:0] imm;
    } idex_t;
    typedef struct packed {
        logic we; logic [4:0] dst; logic mem_rd; logic mem_wr; logic [31:0] alu; logic [31:0] sdata;
    } exmem_t;
    typedef struct packed { logic we; logic [4:0] dst; logic [31:0] data; } memwb_t;

    logic [31:0] pc_q, pc_d, cycle_q, cycle_d;
    ifid_t  ifid_q, ifid_d;
    idex_t  idex_q, idex_d, dec;
    exmem_t exmem_q, exmem_d;
    memwb_t memwb_q, memwb_d;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] sext, rf_rs, rf_rt, rs_v, rt_v, br_tgt;
    logic        use_rs, use_rt, is_br, is_jr, is_j, take, stall, br_haz, lu_haz;
    logic        ex_rs, ex_rt, ml_rs, ml_rt;
    logic [31:0] fa, fb, opb, sum, diff, res, dm_rdata;

    function automatic logic hit(input logic we, input logic [4:0] dst, input logic [4:0] r);
        return we && dst == r && r != 5'd0;
    endfunction

    mips_imem #(.WORDS(IM_WORDS)) IM (
        .clock(clock), .we(1'b0), .waddr('0), .wdata('0), .addr(pc_q[IAW+1:2]), .rdata(if_inst)
    );
    mips_regfile piperegs (
        .clock(clock), .ra1(rs), .ra2(rt), .rd1(rf_rs), .rd2(rf_rt),
        .we(memwb_q.we), .wa(memwb_q.dst), .wd(memwb_q.data)
    );
    mips_dmem #(.WORDS(DM_WORDS)) DM (
        .clock(clock), .addr(exmem_q.alu[DAW+1:2]), .we(exmem_q.mem_wr), .wdata(exmem_q.sdata),
        .rdata(dm_rdata)
    );

    // ID: decode into the EX record
    always_comb begin
        op = ifid_q.inst[31:26]; rs = ifid_q.inst[25:21]; rt = ifid_q.inst[20:16];
        rd = ifid_q.inst[15:11]; funct = ifid_q.inst[5:0];
        sext = {{16{ifid_q.inst[15]}}, ifid_q.inst[15:0]};
        dec = '0;
        dec.rs = rs; dec.rt = rt; dec.a = rf_rs; dec.b = rf_rt; dec.imm = sext;
        use_rs = 1'b0; use_rt = 1'b0; is_br = 1'b0; is_jr = 1'b0; is_j = 1'b0;
        case (op)
            6'h00: begin
                dec.dst = rd;
                use_rs = 1'b1;
                use_rt = funct != 6'h08;
                is_jr = funct == 6'h08;
                dec.we = funct[5:3] == 3'b100;
                dec.ovf_chk = funct == 6'h20 || funct == 6'h22;
                case (funct[2:0])
                    3'd2, 3'd3: dec.op = ALU_SUB;
                    3'd4:       dec.op = ALU_AND;
                    3'd5:       dec.op = ALU_OR;
                    3'd6:       dec.op = ALU_XOR;
                    3'd7:       dec.op = ALU_NOR;
                    default:    dec.op = ALU_ADD;
                endcase
            end
            6'h08: begin dec.we = 1'b1; dec.dst = rt; dec.use_imm = 1'b1; dec.ovf_chk = 1'b1; use_rs = 1'b1; end
            6'h0C, 6'h0D: begin
                dec.we = 1'b1; dec.dst = rt; dec.use_imm = 1'b1; use_rs = 1'b1;
                dec.imm = {16'd0, ifid_q.inst[15:0]};
                dec.op = op[0] ? ALU_OR : ALU_AND;
            end
            6'h23: begin dec.we = 1'b1; dec.dst = rt; dec.mem_rd = 1'b1; dec.use_imm = 1'b1; use_rs = 1'b1; end
            6'h2B: begin dec.mem_wr = 1'b1; dec.use_imm = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
            6'h04, 6'h05: begin is_br = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
            6'h07: begin is_br = 1'b1; use_rs = 1'b1; end
            6'h02: is_j = 1'b1;
            default: ;
        endcase
        if (dec.dst == 5'd0) dec.we = 1'b0;
    end

    // Hazards: lw results are never forwarded into ID; an ALU result still in EX is not ready either.
    always_comb begin
        ex_rs = use_rs && hit(idex_q.we, idex_q.dst, rs);
        ex_rt = use_rt && hit(idex_q.we, idex_q.dst, rt);
        ml_rs = use_rs && exmem_q.mem_rd && hit(exmem_q.we, exmem_q.dst, rs);
        ml_rt = use_rt && exmem_q.mem_rd && hit(exmem_q.we, exmem_q.dst, rt);
        lu_haz = idex_q.mem_rd && (ex_rs || ex_rt);
        br_haz = (is_br || is_jr) && (ex_rs || ex_rt || ml_rs || ml_rt);
        stall = lu_haz || br_haz;
        rs_v = hit(exmem_q.we, exmem_q.dst, rs) ? exmem_q.alu : rf_rs;
        rt_v = hit(exmem_q.we, exmem_q.dst, rt) ? exmem_q.alu : rf_rt;
        take = ((op == 6'h04 && rs_v == rt_v) || (op == 6'h05 && rs_v != rt_v) ||
                (op == 6'h07 && $signed(rs_v) > 0) || is_j || is_jr) && !br_haz;
        br_tgt = is_jr ? rs_v
               : is_j  ? {ifid_q.pc4[31:28], ifid_q.inst[25:0], 2'b00}
               : ifid_q.pc4 + {sext[29:0], 2'b00};
    end

    always_comb begin
        cycle_d = cycle_q + 32'd1;
        pc_d = pc_q + 32'd4;
        ifid_d.inst = if_inst;
        ifid_d.pc4 = pc_q + 32'd4;
        idex_d = dec;
        if (take) begin
            pc_d = br_tgt;
            ifid_d = '0;
        end else if (stall) begin
            pc_d = pc_q;
            ifid_d = ifid_q;
            idex_d = '0;
        end
    end

    // EX: EX/MEM forwarding takes priority over MEM/WB
    always_comb begin
        fa = hit(exmem_q.we, exmem_q.dst, idex_q.rs) ? exmem_q.alu
           : hit(memwb_q.we, memwb_q.dst, idex_q.rs) ? memwb_q.data : idex_q.a;
        fb = hit(exmem_q.we, exmem_q.dst, idex_q.rt) ? exmem_q.alu
           : hit(memwb_q.we, memwb_q.dst, idex_q.rt) ? memwb_q.data : idex_q.b;
        opb = idex_q.use_imm ? idex_q.imm : fb;
        sum = fa + opb;
        diff = fa - opb;
        case (idex_q.op)
            ALU_SUB: res = diff;
            ALU_AND: res = fa & opb;
            ALU_OR:  res = fa | opb;
            ALU_XOR: res = fa ^ opb;
            ALU_NOR: res = ~(fa | opb);
            default: res = sum;
        endcase
        alu_ovf = idex_q.ovf_chk && ((idex_q.op == ALU_SUB)
                ? (fa[31] != opb[31] && diff[31] != fa[31])
                : (fa[31] == opb[31] && sum[31] != fa[31]));
        exmem_d.we = idex_q.we;
`ifdef OVF_SUPPRESS_EN
        exmem_d.we = idex_q.we && !alu_ovf;
`endif
        exmem_d.dst = idex_q.dst;
        exmem_d.mem_rd = idex_q.mem_rd;
        exmem_d.mem_wr = idex_q.mem_wr;
        exmem_d.alu = res;
        exmem_d.sdata = fb;
        memwb_d.we = exmem_q.we;
        memwb_d.dst = exmem_q.dst;
        memwb_d.data = exmem_q.mem_rd ? dm_rdata : exmem_q.alu;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc_q <= '0; cycle_q <= '0; ifid_q <= '0; idex_q <= '0; exmem_q <= '0; memwb_q <= '0;
        end else begin
            pc_q <= pc_d; cycle_q <= cycle_d; ifid_q <= ifid_d;
            idex_q <= idex_d; exmem_q <= exmem_d; memwb_q <= memwb_d;
        end
    end

    assign pc = pc_q;
    assign cycle = cycle_q;
    assign wb_we = memwb_q.we;
    assign wb_reg = memwb_q.dst;
    assign wb_data = memwb_q.data;
endmodule

module mips_imem #(parameter int WORDS = 256) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(WORDS)-1:0] waddr,
    input  logic [31:0]              wdata,
    input  logic [$clog2(WORDS)-1:0] addr,
    output logic [31:0]              rdata
);
    logic [31:0] instructmem [WORDS];
    always_ff @(posedge clock) if (we) instructmem[waddr] <= wdata;
    assign rdata = instructmem[addr];
endmodule

// Write-first: a same-cycle WB write is visible on the read ports.
module mips_regfile (
    input  logic        clock,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] regfile [32];
    always_ff @(posedge clock) if (we && wa != 5'd0) regfile[wa] <= wd;
    assign rd1 = (ra1 == 5'd0) ? '0 : (we && wa == ra1) ? wd : regfile[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : (we && wa == ra2) ? wd : regfile[ra2];
endmodule

module mips_dmem #(parameter int WORDS = 1024) (
    input  logic                     clock,
    input  logic [$clog2(WORDS)-1:0] addr,
    input  logic                     we,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);
    logic [31:0] datamem [WORDS];
    always_ff @(posedge clock) if (we) datamem[addr] <= wdata;
    assign rdata = datamem[addr];
endmodule

// File: tb/tb_mips_pipe_cpu.sv
// Directed bench for mips_pipe_cpu: reset/fetch timing, first write-back latency, then a preloaded
// program whose stored results are compared against a hand-computed table.
module tb_mips_pipe_cpu;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] cycle, pc, if_inst, wb_data;
    logic        wb_we, alu_ovf;
    logic [4:0]  wb_reg;

    int checks = 0;
    int errors = 0;
    int ovf_cnt = 0;
    int np = 0;
    logic [31:0] prog [72];

    typedef struct { int idx; logic [31:0] exp; } dm_vec_t;
    dm_vec_t vecs [16];

    localparam int ADDI = 'h08, ANDI = 'h0C, LW = 'h23, SW = 'h2B, BEQ = 'h04, BNE = 'h05, BGTZ = 'h07;
    localparam int F_ADD = 'h20, F_SUB = 'h22, F_SUBU = 'h23, F_AND = 'h24, F_OR = 'h25;
    localparam int F_XOR = 'h26, F_NOR = 'h27, F_JR = 'h08;
    localparam logic [31:0] HALT_PC = 32'd284;

    mips_pipe_cpu dut (
        .clock(clock), .reset_n(reset_n), .cycle(cycle), .pc(pc), .if_inst(if_inst),
        .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data), .alu_ovf(alu_ovf)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (reset_n === 1'b1 && alu_ovf === 1'b1) ovf_cnt++;

    function automatic logic [31:0] r_op(input int f, input int s, input int t, input int d);
        return {6'd0, 5'(s), 5'(t), 5'(d), 5'd0, 6'(f)};
    endfunction
    function automatic logic [31:0] i_op(input int o, input int s, input int t, input int imm);
        return {6'(o), 5'(s), 5'(t), 16'(imm)};
    endfunction
    function automatic logic [31:0] j_op(input int idx);
        return {6'h02, 26'(idx)};
    endfunction

    task automatic emit(input logic [31:0] w);
        prog[np] = w;
        np++;
    endtask
    task automatic store_next(input int r);
        emit(i_op(ADDI, 8, 8, 4));
        emit(i_op(SW, 8, r, 0));
    endtask
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        // ALU/forwarding block, results land in DM[1..9]
        emit(i_op(ADDI, 0, 8, 'h2000));
        for (int r = 9; r <= 12; r++) emit(r_op(F_XOR, r, r, r));
        emit(i_op(ADDI, 0, 9, 1));
        emit(i_op(ADDI, 0, 10, 2));
        emit(i_op(ADDI, 0, 11, 'hFFFF));
        emit(i_op(LW, 8, 12, 0));
        emit(r_op(F_ADD, 12, 12, 13)); store_next(13);
        emit(r_op(F_ADD, 9, 10, 13));  store_next(13);
        emit(r_op(F_SUB, 9, 11, 13));  store_next(13);
        emit(r_op(F_SUBU, 10, 9, 13)); store_next(13);
        emit(r_op(F_AND, 9, 11, 13));  store_next(13);
        emit(i_op(ANDI, 11, 13, 'h10)); store_next(13);
        emit(r_op(F_OR, 9, 10, 13));   store_next(13);
        emit(r_op(F_NOR, 11, 9, 13));  store_next(13);
        emit(r_op(F_XOR, 11, 9, 13));  store_next(13);
        // bgtz loop at word 36
        emit(i_op(ADDI, 13, 13, 1));
        emit(i_op(BGTZ, 13, 0, 1));
        emit(j_op(36));
        store_next(13);
        // bne not taken
        emit(i_op(BNE, 13, 9, 1));
        emit(r_op(F_XOR, 13, 13, 13));
        store_next(13);
        // jr to word 50 with rs forwarded
        emit(i_op(ADDI, 0, 14, 200));
        emit(r_op(F_XOR, 13, 13, 13));
        emit(r_op(F_JR, 14, 0, 0));
        emit(i_op(ADDI, 13, 13, 16));
        emit(i_op(ADDI, 13, 13, 16));
        emit(i_op(ADDI, 13, 13, 8));
        store_next(13);
        // load-use then WAW
        emit(i_op(ADDI, 0, 14, 'h2000));
        emit(i_op(LW, 14, 9, 0));
        emit(r_op(F_ADD, 10, 11, 9));
        emit(r_op(F_ADD, 9, 9, 11));
        store_next(11);
        // overflow, lw feeding a taken beq, $0 write discard
        emit(r_op(F_ADD, 20, 21, 22));
        store_next(22);
        emit(i_op(LW, 8, 15, 0));
        emit(i_op(BEQ, 15, 22, 1));
        emit(i_op(ADDI, 16, 16, 1));
        emit(i_op(ADDI, 0, 0, 7));
        emit(r_op(F_ADD, 0, 15, 17));
        store_next(17);
        store_next(16);
        emit(j_op(71));

        for (int i = 0; i < 256; i++) dut.IM.instructmem[i] = (i < np) ? prog[i] : 32'd0;
        for (int i = 0; i < 32; i++) dut.piperegs.regfile[i] = 32'd0;
        for (int i = 0; i < 32; i++) dut.DM.datamem[i] = 32'd0;
        dut.piperegs.regfile[20] = 32'h7FFF_FFFF;
        dut.piperegs.regfile[21] = 32'd1;

        vecs[0]  = '{1, 32'd0};    vecs[1]  = '{2, 32'd3};   vecs[2]  = '{3, 32'd2};
        vecs[3]  = '{4, 32'd1};    vecs[4]  = '{5, 32'd1};   vecs[5]  = '{6, 32'h10};
        vecs[6]  = '{7, 32'd3};    vecs[7]  = '{8, 32'd0};   vecs[8]  = '{9, 32'hFFFF_FFFE};
        vecs[9]  = '{10, 32'd1};   vecs[10] = '{11, 32'd0};  vecs[11] = '{12, 32'd8};
        vecs[12] = '{13, 32'd2};   vecs[15] = '{16, 32'd0};  vecs[0].idx = 1;
`ifdef OVF_SUPPRESS_EN
        vecs[13] = '{14, 32'd0};   vecs[14] = '{15, 32'd0};
`else
        vecs[13] = '{14, 32'h8000_0000}; vecs[14] = '{15, 32'h8000_0000};
`endif

        repeat (2) @(posedge clock);
        #1;
        check("reset_pc", pc, 32'd0);
        check("reset_cycle", cycle, 32'd0);
        check("reset_wb_we", {31'd0, wb_we}, 32'd0);
        check("reset_alu_ovf", {31'd0, alu_ovf}, 32'd0);
        check("reset_if_inst", if_inst, prog[0]);
        reset_n = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            @(posedge clock); #1;
            check($sformatf("pc_step%0d", c), pc, 32'(4 * c));
            check($sformatf("cycle_step%0d", c), cycle, 32'(c));
        end

        for (int i = 0; i < 10 && wb_we !== 1'b1; i++) begin
            @(posedge clock); #1;
        end
        check("first_wb_cycle", cycle, 32'd4);
        check("first_wb_we", {31'd0, wb_we}, 32'd1);
        check("first_wb_reg", {27'd0, wb_reg}, 32'd8);
        check("first_wb_data", wb_data, 32'h2000);

        for (int i = 0; i < 3000 && pc !== HALT_PC; i++) begin
            @(posedge clock); #1;
        end
        check("halt_reached", pc, HALT_PC);
        repeat (8) @(posedge clock);
        #1;

        for (int i = 0; i < 16; i++)
            check($sformatf("dm[%0d]", vecs[i].idx), dut.DM.datamem[vecs[i].idx], vecs[i].exp);
        check("reg13", dut.piperegs.regfile[13], 32'd8);
        check("reg9_waw", dut.piperegs.regfile[9], 32'd1);
        check("ovf_count", 32'(ovf_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
